// File: rtl/binary_mul_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package binary_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned wb);
    return $clog2(wb + 1);
  endfunction

endpackage

// File: rtl/binary_mul_addsub.sv
// One shift-add step: adds or subtracts the shifted multiplicand into the accumulator.
module binary_mul_addsub #(
  parameter int unsigned W = 10
) (
  input  logic [W-1:0] acc_i,
  input  logic [W-1:0] a_shift_i,
  input  logic         sub_i,
  output logic [W-1:0] sum_o
);

  assign sum_o = sub_i ? (acc_i - a_shift_i) : (acc_i + a_shift_i);

endmodule

// File: rtl/binary_mul_seq_param.sv
// Sequential radix-2 multiplier: one bit of B per enabled edge, valid/ready on both sides.
module binary_mul_seq_param
  import binary_mul_pkg::*;
#(
  parameter int unsigned WA     = 5,
  parameter int unsigned WB     = 5,
  parameter int unsigned SIGNED = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [WA-1:0]   A,
  input  logic [WB-1:0]   B,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [WA+WB-1:0] P,
  output logic            out_valid,
  input  logic            out_ready
);

  localparam int unsigned WP = WA + WB;
  localparam int unsigned CW = cnt_width(WB);
  localparam logic [CW-1:0] LastIdx = CW'(WB - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WA-1:0] a_q, a_d;
  logic [WB-1:0] b_q, b_d;
  logic [WP-1:0] acc_q, acc_d;

  logic [WP-1:0] a_ext;
  logic [WP-1:0] a_shift;
  logic [WP-1:0] sum;
  logic          b_bit;
  logic          sub;

  always_comb begin
    a_ext = {{WB{1'b0}}, a_q};
    if (SIGNED != 0) begin
      a_ext = {{WB{a_q[WA-1]}}, a_q};
    end
  end

  assign a_shift = a_ext << cnt_q;
  assign b_bit   = |(b_q & (WB'(1) << cnt_q));
  // The MSB of a two's-complement multiplier carries negative weight.
  assign sub     = (SIGNED != 0) && (cnt_q == LastIdx);

  binary_mul_addsub #(
    .W (WP)
  ) u_addsub (
    .acc_i     (acc_q),
    .a_shift_i (a_shift),
    .sub_i     (sub),
    .sum_o     (sum)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (b_bit) begin
          acc_d = sum;
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LastIdx) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // en gates every register, so no handshake can complete while frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
    end else if (en) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && en;
  assign out_valid = (state_q == DONE) && en;
  assign P         = acc_q;

endmodule
